// File: rtl/mulu_seq_xnyn.sv
// Sequential shift-add multiplier with a signed/unsigned mode and a start/busy/rdy handshake.
// The result is sign-magnitude: |x|*|y| on p and the product sign on s, both qualified by rdy.
module mulu_seq_xnyn #(
    parameter int X_WIDTH = 4,
    parameter int Y_WIDTH = 4,
    parameter int P_WIDTH = X_WIDTH + Y_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [X_WIDTH-1:0] x,
    input  logic [Y_WIDTH-1:0] y,
    input  logic               sgn,
    input  logic               start,
    output logic [P_WIDTH-1:0] p,
    output logic               s,
    output logic               rdy,
    output logic               busy
);

    localparam int CW = $clog2(Y_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [X_WIDTH-1:0] mx;
    logic [X_WIDTH-1:0] x_mag;
    logic [Y_WIDTH-1:0] my;
    logic [Y_WIDTH-1:0] y_mag;
    logic               sr;
    logic [P_WIDTH:0]   acc;
    logic [P_WIDTH:0]   acc_nxt;
    logic [X_WIDTH:0]   upper;
    logic [CW-1:0]      cnt;
    logic               accept;
    logic               last;

    // Negating the most-negative value wraps to 2^(W-1), which is the correct unsigned magnitude.
    assign x_mag  = (sgn && x[X_WIDTH-1]) ? -x : x;
    assign y_mag  = (sgn && y[Y_WIDTH-1]) ? -y : y;

    assign accept = start && (state != S_RUN);
    assign last   = (state == S_RUN) && (cnt == CW'(Y_WIDTH - 1));

    // Add into the top X_WIDTH+1 bits, then shift; the carry bit is empty again after the shift.
    assign upper   = acc[P_WIDTH:Y_WIDTH] + (my[0] ? {1'b0, mx} : '0);
    assign acc_nxt = {upper, acc[Y_WIDTH-1:0]} >> 1;

    assign rdy  = (state == S_DONE);
    assign busy = (state == S_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
            S_RUN:          if (last)  state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mx  <= '0;
            my  <= '0;
            sr  <= 1'b0;
            acc <= '0;
            cnt <= '0;
            p   <= '0;
            s   <= 1'b0;
        end else if (accept) begin
            mx  <= x_mag;
            my  <= y_mag;
            sr  <= sgn & (x[X_WIDTH-1] ^ y[Y_WIDTH-1]);
            acc <= '0;
            cnt <= '0;
        end else if (state == S_RUN) begin
            acc <= acc_nxt;
            my  <= my >> 1;
            cnt <= cnt + 1'b1;
            if (last) begin
                p <= acc_nxt[P_WIDTH-1:0];
                s <= sr & (|acc_nxt[P_WIDTH-1:0]);
            end
        end
    end

endmodule

// File: tb/tb_mulu_seq_xnyn.sv
// Bench for mulu_seq_xnyn: a 4x4 instance driven from a vector table and hand sequences,
// and a 6x3 instance swept exhaustively in both modes against an arithmetic reference.
module tb_mulu_seq_xnyn;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4x4 instance
    logic [3:0] xa, ya;
    logic       sgna, starta;
    logic [7:0] pa;
    logic       sa, rdya, busya;

    // 6x3 instance
    logic [5:0] xb;
    logic [2:0] yb;
    logic       sgnb, startb;
    logic [8:0] pb;
    logic       sb, rdyb, busyb;

    mulu_seq_xnyn #(.X_WIDTH(4), .Y_WIDTH(4)) dut_a (
        .clk(clk), .reset(reset), .x(xa), .y(ya), .sgn(sgna), .start(starta),
        .p(pa), .s(sa), .rdy(rdya), .busy(busya)
    );

    mulu_seq_xnyn #(.X_WIDTH(6), .Y_WIDTH(3)) dut_b (
        .clk(clk), .reset(reset), .x(xb), .y(yb), .sgn(sgnb), .start(startb),
        .p(pb), .s(sb), .rdy(rdyb), .busy(busyb)
    );

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q_a[$];   // {s, p[7:0]}
    logic [9:0] exp_q_b[$];   // {s, p[8:0]}
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       sgn;
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] p;
        logic       s;
    } vec_t;

    vec_t vecs[12];

    // ---------------- driver tasks ----------------
    // Drive one start pulse into dut_a; returns at the negedge after the accept edge.
    task automatic start_a(input logic sg, input logic [3:0] xv, input logic [3:0] yv,
                           input logic [7:0] ep, input logic es);
        sgna = sg; xa = xv; ya = yv; starta = 1'b1;
        exp_q_a.push_back({es, ep});
        @(posedge clk);
        @(negedge clk);
        starta = 1'b0;
    endtask

    // Wait for rdy, checking latency and busy length, scrambling inputs while running.
    task automatic wait_a(input string name);
        int edges = 0;
        int busy_cnt = 0;
        logic [8:0] e;
        while (!rdya && edges < 20) begin
            if (busya) busy_cnt++;
            xa = 4'($urandom_range(0, 15));
            ya = 4'($urandom_range(0, 15));
            sgna = 1'($urandom_range(0, 1));
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk({name, " rdy_seen"}, 32'(rdya), 32'd1);
        chk({name, " latency"}, 32'(edges), 32'd4);
        chk({name, " busy_cycles"}, 32'(busy_cnt), 32'd4);
        chk({name, " busy_done"}, 32'(busya), 32'd0);
        if (exp_q_a.size() == 0) begin
            chk({name, " queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q_a.pop_front();
            chk({name, " p"}, 32'(pa), 32'(e[7:0]));
            chk({name, " s"}, 32'(sa), 32'(e[8]));
        end
    endtask

    task automatic run_b(input logic sg, input logic [5:0] xv, input logic [2:0] yv);
        int xm, ym, prod, edges;
        logic es;
        logic [9:0] e;
        xm = (sg && xv[5]) ? 64 - int'(xv) : int'(xv);
        ym = (sg && yv[2]) ? 8 - int'(yv) : int'(yv);
        prod = xm * ym;
        es = sg && (xv[5] != yv[2]) && (prod != 0);
        sgnb = sg; xb = xv; yb = yv; startb = 1'b1;
        exp_q_b.push_back({es, 9'(prod)});
        @(posedge clk);
        @(negedge clk);
        startb = 1'b0;
        edges = 0;
        while (!rdyb && edges < 20) begin
            xb = 6'($urandom_range(0, 63));
            yb = 3'($urandom_range(0, 7));
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        e = exp_q_b.pop_front();
        if (edges != 3 || !rdyb || pb !== e[8:0] || sb !== e[9]) begin
            chk($sformatf("sweep sgn=%0d x=%0d y=%0d lat=%0d p", sg, xv, yv, edges),
                {22'(edges), 1'(sb), pb}, {22'd3, e});
        end else begin
            n_checks++;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0]  = '{1'b0, 4'hF, 4'hF, 8'hE1, 1'b0};
        vecs[1]  = '{1'b1, 4'h8, 4'h3, 8'h18, 1'b1};
        vecs[2]  = '{1'b1, 4'h8, 4'h8, 8'h40, 1'b0};
        vecs[3]  = '{1'b1, 4'h0, 4'hB, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 4'h3, 4'h5, 8'h0F, 1'b0};
        vecs[5]  = '{1'b0, 4'h2, 4'h7, 8'h0E, 1'b0};
        vecs[6]  = '{1'b0, 4'h8, 4'h3, 8'h18, 1'b0};
        vecs[7]  = '{1'b1, 4'h7, 4'hF, 8'h07, 1'b1};
        vecs[8]  = '{1'b1, 4'hF, 4'hF, 8'h01, 1'b0};
        vecs[9]  = '{1'b0, 4'h0, 4'h0, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 4'h5, 4'hA, 8'h1E, 1'b1};
        vecs[11] = '{1'b0, 4'hA, 4'hC, 8'h78, 1'b0};

        reset = 1'b1;
        xa = '0; ya = '0; sgna = 1'b0; starta = 1'b0;
        xb = '0; yb = '0; sgnb = 1'b0; startb = 1'b0;
        @(negedge clk);
        chk("reset p", 32'(pa), 32'd0);
        chk("reset s", 32'(sa), 32'd0);
        chk("reset rdy", 32'(rdya), 32'd0);
        chk("reset busy", 32'(busya), 32'd0);
        chk("reset_b rdy_busy", {30'd0, rdyb, busyb}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 15*15 and a 10-cycle hold of the result
        start_a(1'b0, 4'hF, 4'hF, 8'hE1, 1'b0);
        wait_a("u15x15");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d rdy", i), 32'(rdya), 32'd1);
            chk($sformatf("hold%0d p", i), 32'(pa), 32'hE1);
        end

        // vector table
        for (int i = 0; i < 12; i++) begin
            start_a(vecs[i].sgn, vecs[i].x, vecs[i].y, vecs[i].p, vecs[i].s);
            wait_a($sformatf("vec%0d", i));
        end

        // start held high through RUN: single accept
        sgna = 1'b0; xa = 4'd3; ya = 4'd5; starta = 1'b1;
        exp_q_a.push_back({1'b0, 8'h0F});
        @(posedge clk);
        @(negedge clk);
        wait_a("start_held");
        starta = 1'b0;

        // back-to-back accept from DONE
        start_a(1'b0, 4'd3, 4'd5, 8'h0F, 1'b0);
        wait_a("b2b_first");
        start_a(1'b0, 4'd2, 4'd7, 8'h0E, 1'b0);
        chk("b2b rdy_dropped", 32'(rdya), 32'd0);
        chk("b2b busy_rose", 32'(busya), 32'd1);
        wait_a("b2b_second");

        // asynchronous reset in the middle of an operation
        start_a(1'b0, 4'd9, 4'd13, 8'h75, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst p", 32'(pa), 32'd0);
        chk("midrst s", 32'(sa), 32'd0);
        chk("midrst rdy", 32'(rdya), 32'd0);
        chk("midrst busy", 32'(busya), 32'd0);
        void'(exp_q_a.pop_front());
        starta = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        starta = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_no_accept busy", 32'(busya), 32'd0);
        start_a(1'b0, 4'd9, 4'd13, 8'h75, 1'b0);
        wait_a("after_reset");

        // exhaustive 6x3 sweep, both modes
        for (int sg = 0; sg < 2; sg++)
            for (int xv = 0; xv < 64; xv++)
                for (int yv = 0; yv < 8; yv++)
                    run_b(1'(sg), 6'(xv), 3'(yv));

        chk("queue_a drained", 32'(exp_q_a.size()), 32'd0);
        chk("queue_b drained", 32'(exp_q_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
